// File: rtl/bet_pkg.sv
// bet_pkg: balanced-ternary trit encodings, write FSM states and trit helpers
package bet_pkg;
    localparam logic [1:0] BET_NEG  = 2'b01;
    localparam logic [1:0] BET_ZERO = 2'b11;
    localparam logic [1:0] BET_POS  = 2'b10;
    localparam logic [1:0] BET_INV  = 2'b00;
    localparam int BET_MAX_TRITS = 32;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

    function automatic logic [1:0] bet_sanitize(input logic [1:0] t);
        return (t == BET_INV) ? BET_ZERO : t;
    endfunction

    // Counts invalid trits among the low n trits of a zero-extended word.
    function automatic logic [7:0] bet_count_inv(input logic [2*BET_MAX_TRITS-1:0] d, input int n);
        logic [7:0] c;
        c = '0;
        for (int i = 0; i < BET_MAX_TRITS; i++)
            if (i < n && d[2*i +: 2] == BET_INV) c = c + 8'd1;
        return c;
    endfunction
endpackage

// File: rtl/bet_rr_arb2.sv
// bet_rr_arb2: two-way round-robin arbiter; pointer moves to the loser on advance
module bet_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       grant_idx
);
    logic ptr_q, ptr_d;

    always_comb begin
        grant     = (valid == 2'b11) ? (ptr_q ? 2'b10 : 2'b01) : valid;
        grant_idx = grant[1];
        ptr_d     = advance ? ~grant_idx : ptr_q;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) ptr_q <= 1'b0;
        else     ptr_q <= ptr_d;
endmodule

// File: rtl/bet_latch_write_ctrl.sv
// bet_latch_write_ctrl: arbitrated, sanitized write sequencer driving a bank of
// balanced-ternary D latches with registered setup/strobe/hold enables.
module bet_latch_write_ctrl
    import bet_pkg::*;
#(
    parameter int W      = 3,
    parameter int NWORDS = 4,
    parameter int AW     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [AW-1:0]     req0_addr,
    input  logic [2*W-1:0]    req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [AW-1:0]     req1_addr,
    input  logic [2*W-1:0]    req1_data,
    output logic              req1_ready,
    output logic [2*W-1:0]    lat_data,
    output logic [NWORDS-1:0] lat_en,
    output logic              busy,
    output logic              grant_id,
    output logic [7:0]        inv_count,
    input  logic              inv_clr
);
    state_t              state_q, state_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [2*W-1:0]      lat_data_q, lat_data_d;
    logic [NWORDS-1:0]   lat_en_q, lat_en_d;
    logic                busy_q, busy_d;
    logic                grant_id_q, grant_id_d;
    logic [7:0]          inv_q, inv_d;
    logic [1:0]          grant;
    logic                gidx, accept;
    logic [2*W-1:0]      sel_data, san_data;
    logic [AW-1:0]       sel_addr;
    logic [8:0]          inv_sum;

    bet_rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .valid     ({req1_valid, req0_valid} & {2{state_q == S_IDLE}}),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (gidx)
    );

    assign req0_ready = grant[0] & ~rst;
    assign req1_ready = grant[1] & ~rst;
    assign accept     = |grant;
    assign lat_data   = lat_data_q;
    assign lat_en     = lat_en_q;
    assign busy       = busy_q;
    assign grant_id   = grant_id_q;
    assign inv_count  = inv_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            lat_data_q <= '1;
            lat_en_q   <= '0;
            busy_q     <= 1'b0;
            grant_id_q <= 1'b0;
            inv_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            lat_data_q <= lat_data_d;
            lat_en_q   <= lat_en_d;
            busy_q     <= busy_d;
            grant_id_q <= grant_id_d;
            inv_q      <= inv_d;
        end

    always_comb begin
        state_d = accept ? S_SETUP :
                  (state_q == S_SETUP)  ? S_STROBE :
                  (state_q == S_STROBE) ? S_HOLD : S_IDLE;
    end

    // Outputs are computed from the next state so every latch line is a flop.
    always_comb begin
        sel_data = gidx ? req1_data : req0_data;
        sel_addr = gidx ? req1_addr : req0_addr;
        for (int i = 0; i < W; i++) san_data[2*i +: 2] = bet_sanitize(sel_data[2*i +: 2]);
        inv_sum    = {1'b0, inv_q} + {1'b0, bet_count_inv((2*BET_MAX_TRITS)'(sel_data), W)};
        addr_d     = accept ? sel_addr : addr_q;
        lat_data_d = accept ? san_data : lat_data_q;
        lat_en_d   = (state_d == S_STROBE && 32'(addr_q) < NWORDS) ? (NWORDS'(1) << addr_q) : '0;
        busy_d     = state_d != S_IDLE;
        grant_id_d = accept ? gidx : grant_id_q;
        inv_d      = inv_clr ? '0 : accept ? (inv_sum[8] ? 8'hff : inv_sum[7:0]) : inv_q;
    end
endmodule

// File: tb/tb_bet_latch_write_ctrl.sv
// tb_bet_latch_write_ctrl: directed stimulus with a scoreboard queue checked by a
// monitor that follows each write through its setup/strobe/hold/idle cycles.
module tb_bet_latch_write_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0, inv_clr = 1'b0;
    logic [1:0] req0_addr = '0, req1_addr = '0;
    logic [5:0] req0_data = '0, req1_data = '0;
    logic       req0_ready, req1_ready, busy, grant_id;
    logic [5:0] lat_data;
    logic [2:0] lat_en;
    logic [7:0] inv_count;

    typedef struct {
        logic       gid;
        logic [5:0] data;
        logic [2:0] en;
        logic [7:0] inv;
    } exp_t;

    exp_t sbq[$];
    exp_t cur;
    int   n_chk = 0, n_pass = 0, phase = 0, exp_inv = 0, cyc = 0;

    bet_latch_write_ctrl #(.W(3), .NWORDS(3), .AW(2)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .lat_data(lat_data), .lat_en(lat_en), .busy(busy), .grant_id(grant_id),
        .inv_count(inv_count), .inv_clr(inv_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks so far %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_exp(input bit r, input logic [1:0] a, input logic [5:0] ed, input int ninv, input bit clr);
        exp_t e;
        exp_inv = clr ? 0 : (exp_inv + ninv > 255 ? 255 : exp_inv + ninv);
        e.gid  = r;
        e.data = ed;
        e.en   = (a == 2'd3) ? 3'b000 : 3'(3'b001 << a);
        e.inv  = 8'(exp_inv);
        sbq.push_back(e);
    endtask

    task automatic send(input bit r, input logic [1:0] a, input logic [5:0] d, input logic [5:0] ed,
                        input int ninv, input bit clr, input bit imm);
        int n;
        @(negedge clk);
        if (r) begin req1_valid = 1'b1; req1_addr = a; req1_data = d; end
        else   begin req0_valid = 1'b1; req0_addr = a; req0_data = d; end
        inv_clr = clr;
        #1;
        if (imm) chk("ready_immediate", 32'(r ? req1_ready : req0_ready), 1);
        n = 0;
        while (!(r ? req1_ready : req0_ready) && n < 40) begin @(negedge clk); #1; n++; end
        if (n == 40) chk("accept_timeout", 32'(r ? req1_ready : req0_ready), 1);
        else begin push_exp(r, a, ed, ninv, clr); @(posedge clk); #1; end
        req0_valid = 1'b0; req1_valid = 1'b0; inv_clr = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || phase != 0) && n < 40) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sbq.size()), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        exp_inv = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_lat_data"}, 32'(lat_data), 32'h3f);
        chk({tag, "_lat_en"}, 32'(lat_en), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_grant_id"}, 32'(grant_id), 0);
        chk({tag, "_inv_count"}, 32'(inv_count), 0);
    endtask

    // Monitor: a rising busy marks SETUP; the next three cycles are STROBE, HOLD, IDLE.
    initial forever begin
        @(negedge clk);
        if (rst) phase = 0;
        else if (phase == 0) begin
            if (busy) begin
                chk("pending_writes", 32'(sbq.size()), 1);
                if (sbq.size() != 0) cur = sbq.pop_front();
                chk("setup_lat_en", 32'(lat_en), 0);
                chk("setup_lat_data", 32'(lat_data), 32'(cur.data));
                chk("setup_grant_id", 32'(grant_id), 32'(cur.gid));
                chk("setup_inv_count", 32'(inv_count), 32'(cur.inv));
                chk("setup_ready_low", 32'({req1_ready, req0_ready}), 0);
                phase = 1;
            end
        end else if (phase == 1) begin
            chk("strobe_lat_en", 32'(lat_en), 32'(cur.en));
            chk("strobe_lat_data", 32'(lat_data), 32'(cur.data));
            chk("strobe_busy", 32'(busy), 1);
            chk("strobe_ready_low", 32'({req1_ready, req0_ready}), 0);
            phase = 2;
        end else if (phase == 2) begin
            chk("hold_lat_en", 32'(lat_en), 0);
            chk("hold_lat_data", 32'(lat_data), 32'(cur.data));
            chk("hold_busy", 32'(busy), 1);
            phase = 3;
        end else begin
            chk("idle_busy", 32'(busy), 0);
            chk("idle_lat_en", 32'(lat_en), 0);
            chk("idle_lat_data", 32'(lat_data), 32'(cur.data));
            phase = 0;
        end
    end

    initial begin
        int n, last;
        // Reset values, and ready held low while reset is asserted.
        req0_valid = 1'b1; req1_valid = 1'b1;
        #12;
        chk("rst_ready", 32'({req1_ready, req0_ready}), 0);
        chk_reset_vals("rst");
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Single write: {+1,0,-1} to word 2.
        send(0, 2'd2, 6'b101101, 6'b101101, 0, 0, 1);
        drain();

        // Both requesters valid continuously: grants alternate, 4 cycles apart.
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_addr = 2'd0; req0_data = 6'b011110;
        req1_valid = 1'b1; req1_addr = 2'd1; req1_data = 6'b101001;
        #1;
        last = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!(req0_ready | req1_ready) && n < 20) begin @(negedge clk); #1; n++; end
            chk("alt_ready_seen", 32'(req0_ready | req1_ready), 1);
            chk("alt_grant", 32'({req1_ready, req0_ready}), (k % 2) ? 2 : 1);
            if (k % 2) push_exp(1, 2'd1, 6'b101001, 0, 0);
            else       push_exp(0, 2'd0, 6'b011110, 0, 0);
            if (k > 0) chk("alt_spacing", 32'(cyc - last), 4);
            last = cyc;
            @(negedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();

        // Invalid-trit sanitizing, saturation, and clear winning over an accept.
        do_reset();
        send(1, 2'd1, 6'b000010, 6'b111110, 2, 0, 1);
        for (int k = 0; k < 130; k++) send(0, 2'd0, 6'b000000, 6'b111111, 3, 0, 0);
        drain();
        chk("inv_saturated", 32'(inv_count), 255);
        send(0, 2'd2, 6'b000000, 6'b111111, 3, 1, 1);
        drain();

        // Out-of-range address: full sequence, no enable.
        send(0, 2'd3, 6'b100111, 6'b100111, 0, 0, 1);
        drain();

        // Withdrawn request from req1 while busy leaves the pointer alone.
        do_reset();
        send(0, 2'd0, 6'b111111, 6'b111111, 0, 0, 1);
        req1_valid = 1'b1; req1_addr = 2'd1; req1_data = 6'b010101;
        @(negedge clk); #1;
        chk("withdraw_ready_low", 32'(req1_ready), 0);
        @(negedge clk); @(negedge clk);
        req1_valid = 1'b0;
        drain();
        @(negedge clk);
        req0_valid = 1'b1; req0_addr = 2'd2; req0_data = 6'b101010;
        req1_valid = 1'b1; req1_addr = 2'd1; req1_data = 6'b010101;
        #1;
        chk("ptr_kept_grant", 32'({req1_ready, req0_ready}), 2);
        push_exp(1, 2'd1, 6'b010101, 0, 0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();
        send(0, 2'd2, 6'b101010, 6'b101010, 0, 0, 1);
        drain();

        // Reset during STROBE drops the enable asynchronously.
        do_reset();
        send(0, 2'd1, 6'b011001, 6'b011001, 0, 0, 1);
        @(negedge clk); @(negedge clk);
        #2;
        chk("pre_rst_strobe_en", 32'(lat_en), 3'b010);
        rst = 1'b1;
        #1;
        chk("async_lat_en_drop", 32'(lat_en), 0);
        chk("async_busy_drop", 32'(busy), 0);
        @(negedge clk);
        req1_valid = 1'b1; req1_addr = 2'd2; req1_data = 6'b100110;
        chk_reset_vals("rerst");
        rst = 1'b0;
        exp_inv = 0;
        #1;
        chk("post_rst_ready", 32'(req1_ready), 1);
        push_exp(1, 2'd2, 6'b100110, 0, 0);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/bet_latch_write_ctrl.md
# bet_latch_write_ctrl

Write controller for a bank of balanced-ternary D latches (one latch group per word, each latch a level-sensitive enable/data/hold cell). It arbitrates write requests from two requesters, sanitizes invalid trit encodings, and drives registered, glitch-free per-word latch enables and data with setup and hold margins. It sits between the requesting datapath blocks and the latch bank, and is the only driver of the bank's enable and data lines.

## Interface
- `W`, 3, trits per word; data buses are 2*W bits, trit i at bits [2i+1:2i]
- `NWORDS`, 4, latch words in the bank
- `AW`, 2, address width, ≥ clog2(NWORDS)
- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `req0_valid`  in  1  requester 0 write request
- `req0_addr`  in  AW  requester 0 word address
- `req0_data`  in  2*W  requester 0 trit data
- `req0_ready`  out  1  requester 0 accepted this cycle when high with valid
- `req1_valid`, `req1_addr`, `req1_data`, `req1_ready`: same as requester 0
- `lat_data`  out  2*W  registered data to all latch words
- `lat_en`  out  NWORDS  registered per-word enable, one-hot or zero
- `busy`  out  1  high in any state other than IDLE
- `grant_id`  out  1  requester of the most recently accepted write
- `inv_count`  out  8  saturating count of invalid trits received
- `inv_clr`  in  1  synchronous clear of inv_count

## Operation
- Trit encoding: 2'b01 = −1, 2'b11 = 0, 2'b10 = +1; 2'b00 is invalid and is replaced by 2'b11 on capture.
- FSM states: IDLE → SETUP → STROBE → HOLD → IDLE. No other transitions except reset.
- IDLE: arbitration is combinational. If exactly one valid, that requester is granted. If both are valid, the requester selected by the round-robin pointer is granted. The granted requester's ready is high; all ready signals are low outside IDLE.
- Accept = valid & ready at a rising edge:
  - capture the sanitized data and the address;
  - set grant_id;
  - set the pointer to the other requester;
  - go to SETUP.
- SETUP: lat_data = captured word, lat_en = 0.
- STROBE: lat_en[addr] = 1, lat_data unchanged. If addr ≥ NWORDS, lat_en stays 0; the write is silently dropped but still completes the sequence.
- HOLD: lat_en = 0, lat_data unchanged.
- Return to IDLE. lat_data keeps its last value until the next SETUP.
- inv_count increases by the number of 2'b00 trits in each accepted word and saturates at 255. If inv_clr is high in the same cycle as an accept, the clear wins and that increment is discarded.
- Reset values:
  - FSM = IDLE, lat_en = 0, lat_data = all 2'b11;
  - ready = 0 only while rst is asserted; after release, ready follows arbitration;
  - busy = 0, grant_id = 0, pointer = requester 0, inv_count = 0.
- Reset mid-operation: lat_en drops to 0 asynchronously and the latch bank retains its prior contents. No partial write is retried.

## Timing
- Accept at edge T → SETUP during cycle T+1, STROBE (enable high) during T+2, HOLD during T+3, IDLE during T+4.
- Next accept at the earliest at edge T+4, which gives a maximum throughput of one write per 4 cycles.
- Data is stable 1 cycle before, during and 1 cycle after the enable pulse. The enable is exactly 1 cycle wide.
- All outputs except ready come directly from flops. ready is combinational from the valid inputs, the pointer and the IDLE state.
- A requester must hold valid, addr and data stable until it is accepted. Dropping valid before acceptance withdraws the request with no side effect.

## Structure
- Package `bet_pkg` holds:
  - constants BET_NEG = 2'b01, BET_ZERO = 2'b11, BET_POS = 2'b10, BET_INV = 2'b00;
  - the FSM state enum;
  - function `bet_sanitize` (per-trit 00 → 11);
  - function `bet_count_inv`.
- Sub-module `bet_rr_arb2`: 2-way round-robin arbiter with inputs valid[1:0] and an advance strobe, and outputs grant[1:0] and the grant index.
- The top level holds the FSM, capture registers, output registers and the counter.

## Test plan
- Reset, then req0 writes addr 2 with data {10,11,01} → lat_data = 6'b101101 from T+1, lat_en = 4'b0100 only in T+2, busy high T+1..T+3, ready low during busy.
- req0 and req1 valid continuously after reset → grants alternate 0,1,0,1 with grant_id tracking them, accepts 4 cycles apart, neither requester starved.
- req1 data {00,00,10} → lat_data = 6'b111110 and inv_count = 2. Then 130 all-00 words → inv_count saturates at 255. Then inv_clr asserted together with an accept → inv_count = 0.
- With NWORDS = 3, write to addr 3 → full 4-cycle sequence runs, busy pulses, lat_en stays 0 throughout.
- rst asserted during STROBE → lat_en goes to 0 before the next clock edge. After release, outputs are at reset values and a new request is accepted on the first edge.
- valid dropped by req1 before it is granted → no accept and the pointer is unchanged. A later req0-only request is granted immediately.
